// File: rtl/tt_uart_pkg.sv
// Shared UART definitions for the tile transmitter and the future receiver.
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tt_uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled, one-cycle bit_tick on the last count.
module tt_uart_baud_gen #(
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/tt_uart_tx.sv
// 8N1 UART transmitter driving uio[0]; optional even parity bit under TT_UART_TX_PARITY_EN.
//  state  | meaning
//  IDLE   | line high, waiting for tx_valid && tx_ready
//  START  | start bit (low) for CLK_DIV cycles
//  DATA   | shift[0] on the line, 8 bits LSB first
//  PARITY | even parity of the accepted byte (parity build only)
//  STOP   | stop bit (high) for CLK_DIV cycles
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_oe,
    output logic       busy
);

    uart_state_e state, state_next;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx;
    logic        bit_tick;
    logic        accept;
    logic        line_next;
`ifdef TT_UART_TX_PARITY_EN
    logic        parity_q;
`endif

    assign tx_ready = (state == IDLE) && ena && tx_oe;
    assign accept   = tx_valid && tx_ready;

    tt_uart_baud_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        line_next  = IDLE_LEVEL;
        unique case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                line_next = 1'b0;
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                line_next = shift_q[0];
                if (bit_tick && bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef TT_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef TT_UART_TX_PARITY_EN
            PARITY: begin
                line_next = parity_q;
                if (bit_tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line follows the state one cycle late, so the start bit falls on the edge after accept;
    // busy tracks the next state so it covers exactly the frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_idx <= '0;
            tx_out  <= IDLE_LEVEL;
            tx_oe   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tx_oe  <= 1'b1;
            tx_out <= line_next;
            busy   <= (state_next != IDLE);
            if (accept) begin
                shift_q <= tx_data;
                bit_idx <= '0;
            end else if (state == DATA && bit_tick) begin
                shift_q <= shift_q >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

`ifdef TT_UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^tx_data;
        end
    end
`endif

endmodule
